case_6_prod_accum: RTL and testbench

CASE_6_PROD_ACCUM -- requirements
Module: case_6_prod_accum

---
 rtl/case_6_pkg.sv | 30 +++
 rtl/case_6_res_buf.sv | 46 ++++
 rtl/case_6_prod_accum.sv | 124 ++++++++++++
 tb/tb_case_6_prod_accum.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_6_pkg.sv
// Shared types and helpers for the product accumulator.
// Holds the FSM encoding and the signed saturation function.
package case_6_pkg;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam int SAT_W = 64;

    // Clamp a signed value to the range of a w-bit signed number.
    function automatic logic signed [SAT_W-1:0] sat_to(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/case_6_res_buf.sv
// Two-entry result buffer: output register plus one pending slot.
// The FSM in the parent decides which slot a new result lands in.
module case_6_res_buf
    import case_6_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_out,
    input  logic                ld_pend,
    input  logic                mv_pend,
    input  logic signed [W-1:0] din,
    input  logic                rd,
    output logic signed [W-1:0] dout,
    output logic                valid
);

    logic signed [W-1:0] pend_q;

    // Output register: load new/pending result, else drop when consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (ld_out) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (mv_pend) begin
            dout  <= pend_q;
            valid <= 1'b1;
        end else if (valid && rd) begin
            valid <= 1'b0;
        end
    end

    // Pending register: parks a result while the output is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else if (ld_pend) begin
            pend_q <= din;
        end
    end

endmodule

// File: rtl/case_6_prod_accum.sv
// Frame accumulator: sums FRAME_LEN signed products, emits saturated sum.
// Backpressure parks one result, then stalls the input until drained.
module case_6_prod_accum
    import case_6_pkg::*;
#(
    parameter int DIN_WIDTH = 12,
    parameter int ACC_WIDTH = 20,
    parameter int OUT_WIDTH = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic signed [DIN_WIDTH-1:0] prod_din,
    input  logic                        prod_valid,
    output logic                        prod_ready,
    input  logic                        acc_clr,
    output logic signed [OUT_WIDTH-1:0] acc_dout,
    output logic                        acc_valid,
    input  logic                        acc_ready
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    state_t state;
    state_t state_nx;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [CW-1:0]               cnt_q;
    logic [CW-1:0]               cnt_base;
    logic signed [OUT_WIDTH-1:0] res;

    logic accept;
    logic last;
    logic fire;
    logic pop;
    logic ld_out;
    logic ld_pend;
    logic mv_pend;

    assign prod_ready = (state == ST_ACC) && !ap_rst;
    assign accept     = prod_valid && prod_ready;
    assign pop        = acc_valid && acc_ready;

    // A clear this cycle makes the incoming sample the first of a frame.
    assign acc_base = acc_clr ? '0 : acc_q;
    assign cnt_base = acc_clr ? '0 : cnt_q;
    assign sum      = acc_base + ACC_WIDTH'(prod_din);
    assign last     = (cnt_base == LAST);
    assign fire     = accept && last;
    assign res      = OUT_WIDTH'(sat_to(SAT_W'(sum), OUT_WIDTH));

    // Running sum and sample count, cleared at frame end or on acc_clr.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            if (last) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_base + CW'(1);
            end
        end else begin
            acc_q <= acc_base;
            cnt_q <= cnt_base;
        end
    end

    // FSM state register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_nx;
        end
    end

    // Route finished results and track whether input must stall.
    always_comb begin
        state_nx = state;
        ld_out   = 1'b0;
        ld_pend  = 1'b0;
        mv_pend  = 1'b0;
        unique case (state)
            ST_ACC: begin
                if (fire) begin
                    if (!acc_valid || acc_ready) begin
                        ld_out = 1'b1;
                    end else begin
                        ld_pend  = 1'b1;
                        state_nx = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (pop) begin
                    mv_pend  = 1'b1;
                    state_nx = ST_ACC;
                end
            end
            default: state_nx = ST_ACC;
        endcase
    end

    case_6_res_buf #(
        .W(OUT_WIDTH)
    ) u_buf (
        .clk    (ap_clk),
        .rst    (ap_rst),
        .ld_out (ld_out),
        .ld_pend(ld_pend),
        .mv_pend(mv_pend),
        .din    (res),
        .rd     (acc_ready),
        .dout   (acc_dout),
        .valid  (acc_valid)
    );

endmodule

// File: tb/tb_case_6_prod_accum.sv
// Testbench for case_6_prod_accum (FRAME_LEN=4, OUT_WIDTH=12).
// Directed scenarios plus randomized traffic against a sum model.
module tb_case_6_prod_accum;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [11:0] prod_din = '0;
    logic               prod_valid = 1'b0;
    logic               prod_ready;
    logic               acc_clr = 1'b0;
    logic signed [11:0] acc_dout;
    logic               acc_valid;
    logic               acc_ready = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    case_6_prod_accum #(
        .DIN_WIDTH(12),
        .ACC_WIDTH(20),
        .OUT_WIDTH(12),
        .FRAME_LEN(4)
    ) dut (
        .ap_clk    (clk),
        .ap_rst    (rst),
        .prod_din  (prod_din),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .acc_clr   (acc_clr),
        .acc_dout  (acc_dout),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready)
    );

    function automatic int sat12(input int s);
        if (s > 2047) return 2047;
        if (s < -2048) return -2048;
        return s;
    endfunction

    // Drive one cycle at negedge, observe outputs, then pass the posedge.
    task automatic cycle(input logic v, input logic signed [11:0] d,
                         input logic r, input logic c,
                         output logic ov, output logic signed [11:0] od,
                         output logic pr);
        @(negedge clk);
        prod_valid = v;
        prod_din   = d;
        acc_ready  = r;
        acc_clr    = c;
        #1;
        ov = acc_valid;
        od = acc_dout;
        pr = prod_ready;
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic ov, pr;
        logic signed [11:0] od;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (acc_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid: got %b want 0", acc_valid);
        end
        total++;
        if (prod_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_ready: got %b want 0", prod_ready);
        end
        total++;
        if (acc_dout !== 12'sd0) begin
            bad++;
            $display("FAIL rst_dout: got %0d want 0", acc_dout);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0, 0, 0, ov, od, pr);
        total++;
        if (pr !== 1'b1) begin
            bad++;
            $display("FAIL rel_ready: got %b want 1", pr);
        end
    endtask

    task automatic test_zero_sum();
        int s[4] = '{100, -50, 25, -75};
        int early = 0;
        logic ov, pr;
        logic signed [11:0] od;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 12'(s[i]), 1, 0, ov, od, pr);
            if (ov) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL zero_early: got %0d valid cycles want 0", early);
        end
        cycle(0, 0, 1, 0, ov, od, pr);
        total++;
        if (ov !== 1'b1 || od !== 12'sd0) begin
            bad++;
            $display("FAIL zero_res: got v=%b d=%0d want v=1 d=0", ov, od);
        end
        cycle(0, 0, 1, 0, ov, od, pr);
        total++;
        if (ov !== 1'b0) begin
            bad++;
            $display("FAIL zero_once: got v=%b want 0", ov);
        end
    endtask

    task automatic test_saturate();
        int in_v[2] = '{2047, -2048};
        int want[2] = '{2047, -2048};
        logic ov, pr;
        logic signed [11:0] od;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) cycle(1, 12'(in_v[k]), 1, 0, ov, od, pr);
            cycle(0, 0, 1, 0, ov, od, pr);
            total++;
            if (ov !== 1'b1 || od !== 12'(want[k])) begin
                bad++;
                $display("FAIL sat_%0d: got v=%b d=%0d want v=1 d=%0d",
                         k, ov, od, want[k]);
            end
        end
        cycle(0, 0, 1, 0, ov, od, pr);
    endtask

    task automatic test_stall();
        logic ov, pr;
        logic signed [11:0] od;
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, ov, od, pr);
        for (int i = 0; i < 4; i++) cycle(1, 2, 0, 0, ov, od, pr);
        cycle(0, 0, 0, 0, ov, od, pr);
        total++;
        if (pr !== 1'b0 || ov !== 1'b1 || od !== 12'sd4) begin
            bad++;
            $display("FAIL stall_enter: got r=%b v=%b d=%0d want r=0 v=1 d=4",
                     pr, ov, od);
        end
        cycle(0, 0, 0, 0, ov, od, pr);
        total++;
        if (ov !== 1'b1 || od !== 12'sd4 || pr !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold: got v=%b d=%0d r=%b want v=1 d=4 r=0",
                     ov, od, pr);
        end
        cycle(0, 0, 1, 0, ov, od, pr);
        total++;
        if (ov !== 1'b1 || od !== 12'sd4) begin
            bad++;
            $display("FAIL stall_first: got v=%b d=%0d want v=1 d=4", ov, od);
        end
        cycle(0, 0, 1, 0, ov, od, pr);
        total++;
        if (ov !== 1'b1 || od !== 12'sd8 || pr !== 1'b1) begin
            bad++;
            $display("FAIL stall_second: got v=%b d=%0d r=%b want v=1 d=8 r=1",
                     ov, od, pr);
        end
        cycle(0, 0, 1, 0, ov, od, pr);
        total++;
        if (ov !== 1'b0) begin
            bad++;
            $display("FAIL stall_drain: got v=%b want 0", ov);
        end
    endtask

    task automatic test_clear();
        int s[6] = '{10, 20, 5, 6, 7, 8};
        logic ov, pr;
        logic signed [11:0] od;
        for (int i = 0; i < 6; i++) cycle(1, 12'(s[i]), 1, (i == 2), ov, od, pr);
        cycle(0, 0, 1, 0, ov, od, pr);
        total++;
        if (ov !== 1'b1 || od !== 12'sd26) begin
            bad++;
            $display("FAIL clr_res: got v=%b d=%0d want v=1 d=26", ov, od);
        end
        cycle(0, 0, 1, 0, ov, od, pr);
    endtask

    task automatic test_reset_mid();
        logic ov, pr;
        logic signed [11:0] od;
        for (int i = 0; i < 3; i++) cycle(1, 12'(i + 1), 1, 0, ov, od, pr);
        #2;
        prod_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (acc_valid !== 1'b0 || prod_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid: got v=%b r=%b want v=0 r=0",
                     acc_valid, prod_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, ov, od, pr);
        cycle(0, 0, 0, 0, ov, od, pr);
        total++;
        if (pr !== 1'b0 || ov !== 1'b1) begin
            bad++;
            $display("FAIL rststall_pre: got r=%b v=%b want r=0 v=1", pr, ov);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (acc_valid !== 1'b0 || prod_ready !== 1'b0) begin
            bad++;
            $display("FAIL rststall: got v=%b r=%b want v=0 r=0",
                     acc_valid, prod_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1, 12'(i + 1), 1, 0, ov, od, pr);
        cycle(0, 0, 1, 0, ov, od, pr);
        total++;
        if (ov !== 1'b1 || od !== 12'sd10) begin
            bad++;
            $display("FAIL rst_after: got v=%b d=%0d want v=1 d=10", ov, od);
        end
        cycle(0, 0, 1, 0, ov, od, pr);
        total++;
        if (ov !== 1'b0) begin
            bad++;
            $display("FAIL rst_nopend: got v=%b want 0", ov);
        end
    endtask

    task automatic test_random();
        logic ov, pr, v, r, c;
        logic signed [11:0] od, d, e;
        logic signed [11:0] q[$];
        int sum = 0;
        int cnt = 0;
        int frames = 0;
        int results = 0;
        int cyc = 0;
        while (frames < 1000 && cyc < 30000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 4) < 3);
            c = ($urandom_range(0, 49) == 0);
            d = 12'($urandom);
            cycle(v, d, r, c, ov, od, pr);
            if (ov && r) begin
                results++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra: got d=%0d want none", od);
                end else begin
                    e = q.pop_front();
                    if (od !== e) begin
                        bad++;
                        $display("FAIL rnd_data: got %0d want %0d", od, e);
                    end
                end
            end
            if (c) begin
                sum = 0;
                cnt = 0;
            end
            if (v && pr) begin
                sum += int'(d);
                cnt++;
                if (cnt == 4) begin
                    q.push_back(12'(sat12(sum)));
                    frames++;
                    sum = 0;
                    cnt = 0;
                end
            end
            cyc++;
        end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 0, ov, od, pr);
            if (ov) begin
                results++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra: got d=%0d want none", od);
                end else begin
                    e = q.pop_front();
                    if (od !== e) begin
                        bad++;
                        $display("FAIL rnd_data: got %0d want %0d", od, e);
                    end
                end
            end
        end
        total++;
        if (frames < 1000) begin
            bad++;
            $display("FAIL rnd_timeout: got %0d frames want 1000", frames);
        end
        total++;
        if (q.size() != 0 || results != frames) begin
            bad++;
            $display("FAIL rnd_count: got %0d results want %0d", results, frames);
        end
    endtask

    initial begin
        test_reset();
        test_zero_sum();
        test_saturate();
        test_stall();
        test_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
